parzen_window_ctrl: RTL and testbench
=====================================

PARZEN_WINDOW_CTRL -- requirements
Module: parzen_window_ctrl

Interface
REQ-001 Parameter WINDOW_SIZE_POW2, default 10, SHALL set frame length N = 2^WINDOW_SIZE_POW2 coefficients.
REQ-002 Parameter GEN_LATENCY, default 3, SHALL be the fixed coefficient-generator latency in cycles, legal range 1..8.
REQ-003 Parameter COEFF_BITS, default 26, SHALL be the coefficient word width.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-006 start  in  1  frame request; sampled only in IDLE.
REQ-007 abort  in  1  terminates the current frame.
REQ-008 busy  out  1  high whenever state is not IDLE.
REQ-009 done  out  1  one-cycle pulse when the last coefficient of a frame is accepted downstream.
REQ-010 gen_idx  out  WINDOW_SIZE_POW2  |n| index driven to the generator.
REQ-011 gen_idx_valid  out  1  gen_idx qualifier; the generator cannot stall.
REQ-012 gen_coeff  in  COEFF_BITS  generator result, valid exactly GEN_LATENCY cycles after its gen_idx_valid.
REQ-013 win_coeff  out  COEFF_BITS  coefficient to the consumer.
REQ-014 win_valid  out  1  win_coeff qualifier.
REQ-015 win_ready  in  1  consumer accept; a transfer occurs when win_valid and win_ready are both high.
REQ-016 win_last  out  1  high with the frame's final coefficient.

Function
REQ-017 States SHALL be IDLE, ISSUE and DRAIN; start in IDLE moves to ISSUE; issuing the Nth index moves to DRAIN; the final transfer moves to IDLE.
REQ-018 Per frame, the index sequence SHALL be N/2, N/2-1, ..., 1, 0, 1, ..., N/2-1, which is exactly N indices.
REQ-019 The first gen_idx_valid SHALL occur in the cycle after start is sampled.
REQ-020 Returned coefficients SHALL be buffered in an output FIFO of depth GEN_LATENCY+2, delivered in issue order, with registered win_* outputs.
REQ-021 Issue SHALL happen only while fifo_count + inflight < GEN_LATENCY+2, so FIFO overflow is impossible under any win_ready pattern.
REQ-022 With win_ready held high, the block SHALL sustain one index per cycle, and the first win_valid SHALL occur GEN_LATENCY+2 cycles after start is sampled.
REQ-023 win_coeff, win_valid and win_last SHALL hold stable while win_valid is high and win_ready is low.
REQ-024 start SHALL be ignored while busy is high, including the cycle in which done pulses.
REQ-025 Asserting abort in ISSUE or DRAIN SHALL return the block to IDLE next cycle, empty the FIFO, discard in-flight returns, force win_valid low, and suppress done.
REQ-026 When abort and start are high in the same IDLE cycle, abort SHALL win and no frame starts.
REQ-027 The inflight count SHALL track a GEN_LATENCY-deep valid shift register; abort SHALL clear it.

Reset
REQ-028 While rst_n is low, the block SHALL be in IDLE with busy, done, gen_idx_valid, win_valid and win_last at 0, gen_idx = N/2, win_coeff = 0, the FIFO empty and the inflight count at 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no done pulse; operation SHALL resume on the first clk edge after rst_n rises.

Configuration
REQ-030 With PARZEN_WIN_REPEAT_EN defined, completing a frame SHALL restart issue at index N/2 with no bubble; done SHALL pulse per frame and the block SHALL leave the frame loop only on abort or reset.
REQ-031 With PARZEN_WIN_REPEAT_EN undefined, the block SHALL be single-shot and return to IDLE after each frame.

Verification
REQ-032 WINDOW_SIZE_POW2=3, GEN_LATENCY=3, win_ready=1, one start pulse -> gen_idx = 4,3,2,1,0,1,2,3 on consecutive cycles; 8 transfers; win_last and done on the 8th transfer; busy then falls.
REQ-033 Same configuration with win_ready low for 20 cycles after start -> issue stops with exactly 5 coefficients held; there is no loss or reorder after release; done fires once.
REQ-034 Abort asserted on the 3rd issued index -> IDLE next cycle, win_valid=0, no done; a new start then produces the full sequence from index 4.
REQ-035 start pulsed while busy and in the done cycle -> ignored, with exactly one frame produced; abort+start together in IDLE -> busy stays 0.
REQ-036 rst_n pulsed low mid-DRAIN -> all outputs match REQ-028 immediately, with no stale win_valid after release.
REQ-037 With PARZEN_WIN_REPEAT_EN defined and win_ready=1, run 3 frames -> 24 contiguous transfers with done pulses at transfers 8, 16 and 24.

Source files
------------

// File: rtl/parzen_window_ctrl_if.sv
// Handshake bundle for parzen_window_ctrl: frame control, generator, stream.
// slave: the controller side; master: the environment (requester/generator/sink).
// Signals: start, abort, busy, done; gen_idx, gen_idx_valid, gen_coeff;
//          win_coeff, win_valid, win_ready, win_last.
interface parzen_window_ctrl_if #(
  parameter int IDX_W      = 10,
  parameter int COEFF_BITS = 26
);
  logic                  start;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic [IDX_W-1:0]      gen_idx;
  logic                  gen_idx_valid;
  logic [COEFF_BITS-1:0] gen_coeff;
  logic [COEFF_BITS-1:0] win_coeff;
  logic                  win_valid;
  logic                  win_ready;
  logic                  win_last;

  modport slave (
    input  start, abort, gen_coeff, win_ready,
    output busy, done, gen_idx, gen_idx_valid,
    output win_coeff, win_valid, win_last
  );

  modport master (
    output start, abort, gen_coeff, win_ready,
    input  busy, done, gen_idx, gen_idx_valid,
    input  win_coeff, win_valid, win_last
  );
endinterface

// File: rtl/parzen_window_ctrl.sv
// Parzen window coefficient sequencer: issues |n| indices to a fixed-latency
// generator and streams results through a small FIFO with registered outputs.
// Ports: clk, rst_n (async active-low), bus (parzen_window_ctrl_if.slave).
// Build option: PARZEN_WIN_REPEAT_EN loops frames back-to-back until abort.
module parzen_window_ctrl #(
  parameter int WINDOW_SIZE_POW2 = 10,
  parameter int GEN_LATENCY      = 3,
  parameter int COEFF_BITS       = 26
) (
  input  logic                 clk,
  input  logic                 rst_n,
  parzen_window_ctrl_if.slave  bus
);
  localparam int W     = WINDOW_SIZE_POW2;
  localparam int N     = 1 << W;
  localparam int L     = GEN_LATENCY;
  localparam int DEPTH = L + 2;
  localparam int QD    = DEPTH - 1;
  localparam int PW    = (QD > 1) ? $clog2(QD) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [W-1:0] HALF  = W'(N / 2);
  localparam logic [W-1:0] LASTC = W'(N - 1);
`ifdef PARZEN_WIN_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    idx_q, idx_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic            dn_q, dn_d;
  logic [L-1:0]    vsr_q, lsr_q;
  logic [CW-1:0]   infl_q, fc_q;
  logic [PW-1:0]   wp_q, rp_q;
  logic [COEFF_BITS:0] mem_q [QD];
  logic [COEFF_BITS-1:0] wc_q;
  logic            wv_q, wl_q;

  logic          ret, ret_last, issue, last_iss;
  logic          out_free, push, rd, fin;
  logic [CW-1:0] occ;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(QD - 1)) ? '0 : p + 1'b1;
  endfunction

  // Output register counts as one FIFO slot, so occupancy covers it too.
  assign ret      = vsr_q[L-1];
  assign ret_last = lsr_q[L-1];
  assign occ      = fc_q + CW'(wv_q) + infl_q;
  assign issue    = (state_q == ISSUE) && (occ < CW'(DEPTH)) && !bus.abort;
  assign last_iss = issue && (cnt_q == LASTC);
  assign out_free = !wv_q || bus.win_ready;
  assign rd       = out_free && (fc_q != '0);
  assign push     = ret && !(out_free && (fc_q == '0));
  assign fin      = wv_q && bus.win_ready && wl_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dn_d    = dn_q;
    unique case (state_q)
      IDLE: if (bus.start && !bus.abort) state_d = ISSUE;
      ISSUE: begin
        if (last_iss) begin
          idx_d = HALF;
          cnt_d = '0;
          dn_d  = 1'b1;
          if (!REPEAT) state_d = DRAIN;
        end else if (issue) begin
          cnt_d = cnt_q + 1'b1;
          if (!dn_q) begin
            idx_d = idx_q + 1'b1;
          end else if (idx_q == '0) begin
            idx_d = W'(1);
            dn_d  = 1'b0;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      DRAIN: if (fin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort) begin
      state_d = IDLE;
      idx_d   = HALF;
      cnt_d   = '0;
      dn_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= HALF;
      cnt_q   <= '0;
      dn_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dn_q    <= dn_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {ret_last, bus.gen_coeff};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsr_q  <= '0;
      lsr_q  <= '0;
      infl_q <= '0;
      fc_q   <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      wv_q   <= 1'b0;
      wl_q   <= 1'b0;
      wc_q   <= '0;
    end else if (bus.abort) begin
      vsr_q  <= '0;
      lsr_q  <= '0;
      infl_q <= '0;
      fc_q   <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      wv_q   <= 1'b0;
      wl_q   <= 1'b0;
      wc_q   <= '0;
    end else begin
      vsr_q  <= (vsr_q << 1) | L'(issue);
      lsr_q  <= (lsr_q << 1) | L'(last_iss);
      infl_q <= infl_q + CW'(issue) - CW'(ret);
      fc_q   <= fc_q + CW'(push) - CW'(rd);
      if (push) wp_q <= nxt(wp_q);
      if (rd) rp_q <= nxt(rp_q);
      // Empty queue lets a returning coefficient bypass into the output reg.
      if (out_free) begin
        if (rd) begin
          {wl_q, wc_q} <= mem_q[rp_q];
          wv_q <= 1'b1;
        end else if (ret) begin
          {wl_q, wc_q} <= {ret_last, bus.gen_coeff};
          wv_q <= 1'b1;
        end else begin
          wv_q <= 1'b0;
          wl_q <= 1'b0;
        end
      end
    end
  end

  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = fin && !bus.abort;
  assign bus.gen_idx       = idx_q;
  assign bus.gen_idx_valid = issue;
  assign bus.win_coeff     = wc_q;
  assign bus.win_valid     = wv_q;
  assign bus.win_last      = wl_q;
endmodule

// File: tb/tb_parzen_window_ctrl.sv
// Self-checking bench for parzen_window_ctrl (N=8, latency 3).
// Generator model tags each coefficient with an issue serial and the index.
module tb_parzen_window_ctrl;
  localparam int W  = 3;
  localparam int L  = 3;
  localparam int CB = 16;
  localparam int N  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  parzen_window_ctrl_if #(.IDX_W(W), .COEFF_BITS(CB)) bus ();

  parzen_window_ctrl #(
    .WINDOW_SIZE_POW2(W),
    .GEN_LATENCY(L),
    .COEFF_BITS(CB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // generator: result appears exactly L cycles after its request
  logic          vs = 1'b0;
  logic [W-1:0]  is_ = '0;
  logic [L-1:0]  gv = '0;
  logic [CB-1:0] gd [L];
  int            ser = 0;

  always @(negedge clk) begin
    vs  <= bus.gen_idx_valid;
    is_ <= bus.gen_idx;
  end

  always @(posedge clk) begin
    gv    <= {gv[L-2:0], vs};
    gd[0] <= {8'(ser), 8'(is_)};
    for (int i = 1; i < L; i++) gd[i] <= gd[i-1];
    if (vs) ser <= ser + 1;
  end

  assign bus.gen_coeff = gv[L-1] ? gd[L-1] : 16'hDEAD;

  // monitor
  typedef struct {
    logic [CB-1:0] c;
    logic          l;
    logic          d;
    int            cyc;
  } xfer_t;

  xfer_t rx[$];
  int cyc = 0, dones = 0, stall_bad = 0, done_bad = 0;
  logic pv = 1'b0, pr = 1'b0, pl = 1'b0, pa = 1'b0;
  logic [CB-1:0] pc = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.win_valid && bus.win_ready)
      rx.push_back('{c: bus.win_coeff, l: bus.win_last, d: bus.done, cyc: cyc});
    if (bus.done) dones <= dones + 1;
    if (bus.done !== (bus.win_valid && bus.win_ready && bus.win_last && !bus.abort))
      done_bad <= done_bad + 1;
    if (rst_n && pv && !pr && !pa &&
        (!bus.win_valid || bus.win_coeff !== pc || bus.win_last !== pl))
      stall_bad <= stall_bad + 1;
    pv <= bus.win_valid && rst_n;
    pr <= bus.win_ready;
    pc <= bus.win_coeff;
    pl <= bus.win_last;
    pa <= bus.abort || !rst_n;
  end

  int total = 0, bad = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int idx_of(input int k);
    return (k <= N / 2) ? (N / 2 - k) : (k - N / 2);
  endfunction

  task automatic start_frame(output int s0, output int base);
    tick();
    bus.start = 1'b1;
    s0 = ser;
    base = rx.size();
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    check(nm, bus.busy, 0);
  endtask

  task automatic check_frame(input int base, input int s0, input string nm);
    check({nm, "_count"}, rx.size() - base, 8);
    for (int k = 0; k < 8; k++) begin
      if (base + k < rx.size())
        check({nm, "_xfer"}, {rx[base+k].c, rx[base+k].l, rx[base+k].d},
              {8'(s0 + k), 8'(idx_of(k)), k == 7, k == 7});
    end
  endtask

  typedef struct {
    logic       st;
    logic       busy;
    logic       giv;
    logic [2:0] gi;
    logic       wv;
    logic       wl;
    logic       dn;
  } vec_t;

  vec_t tbl[14];
  int s0, base, d0;
  logic [7:0] got;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.win_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("reset_state",
          {bus.busy, bus.done, bus.gen_idx_valid, bus.win_valid, bus.win_last, bus.gen_idx, bus.win_coeff},
          {5'b0, 3'd4, 16'h0});
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

`ifdef PARZEN_WIN_REPEAT_EN
    start_frame(s0, base);
    d0 = dones;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (dones - d0 >= 3) break;
      tick();
    end
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    @(negedge clk);
    check("rep_abort_idle", bus.busy, 0);
    check("rep_dones", (dones - d0 >= 3), 1);
    check("rep_count", (rx.size() - base >= 24), 1);
    for (int k = 0; k < 24; k++) begin
      if (base + k < rx.size())
        check("rep_xfer",
              {rx[base+k].c, rx[base+k].l, rx[base+k].d, 32'(rx[base+k].cyc - rx[base].cyc)},
              {8'(s0 + k), 8'(idx_of(k % 8)), k % 8 == 7, k % 8 == 7, 32'(k)});
    end
`else
    // single frame, cycle-exact
    for (int i = 0; i < 14; i++) begin
      tick();
      bus.start = tbl[i].st;
      if (i == 0) begin
        s0 = ser;
        base = rx.size();
      end
      @(negedge clk);
      got = {bus.busy, bus.gen_idx_valid,
             tbl[i].giv ? bus.gen_idx : 3'd0,
             bus.win_valid, bus.win_last, bus.done};
      check($sformatf("vec%0d", i), got,
            {tbl[i].busy, tbl[i].giv, tbl[i].gi, tbl[i].wv, tbl[i].wl, tbl[i].dn});
    end
    check_frame(base, s0, "basic");
    if (rx.size() >= base + 8)
      check("basic_contig", rx[base+7].cyc - rx[base].cyc, 7);

    // consumer stalled for 20 cycles
    tick();
    bus.win_ready = 1'b0;
    bus.start = 1'b1;
    s0 = ser;
    base = rx.size();
    d0 = dones;
    tick();
    bus.start = 1'b0;
    repeat (19) tick();
    @(negedge clk);
    check("stall_issued", ser - s0, 5);
    check("stall_held", bus.win_valid, 1);
    tick();
    bus.win_ready = 1'b1;
    wait_idle(40, "stall_idle");
    check_frame(base, s0, "stall");
    check("stall_done", dones - d0, 1);

    // abort on the 3rd issued index
    start_frame(s0, base);
    tick();
    tick();
    bus.abort = 1'b1;
    d0 = dones;
    tick();
    bus.abort = 1'b0;
    @(negedge clk);
    check("abort_idle", {bus.busy, bus.win_valid}, 2'b00);
    repeat (10) tick();
    check("abort_nodone", dones - d0, 0);
    check("abort_noxfer", rx.size() - base, 0);
    start_frame(s0, base);
    wait_idle(30, "after_abort_idle");
    check_frame(base, s0, "after_abort");

    // start held through the frame including the done cycle
    tick();
    bus.start = 1'b1;
    s0 = ser;
    base = rx.size();
    d0 = dones;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.done) break;
      tick();
    end
    tick();
    bus.start = 1'b0;
    repeat (12) tick();
    @(negedge clk);
    check("busy_start_idle", bus.busy, 0);
    check("busy_start_done", dones - d0, 1);
    check_frame(base, s0, "busy_start");

    // abort wins over start in IDLE
    tick();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    check("abort_start", {bus.busy, bus.gen_idx_valid}, 2'b00);
    tick();
    @(negedge clk);
    check("abort_start2", bus.busy, 0);

    // reset in DRAIN
    start_frame(s0, base);
    repeat (8) tick();
    @(negedge clk);
    check("in_drain", {bus.busy, bus.gen_idx_valid}, 2'b10);
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_drain",
          {bus.busy, bus.done, bus.gen_idx_valid, bus.win_valid, bus.win_last, bus.gen_idx, bus.win_coeff},
          {5'b0, 3'd4, 16'h0});
    d0 = dones;
    base = rx.size();
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    @(negedge clk);
    check("rst_quiet", {32'(rx.size() - base), 32'(dones - d0), 1'b0, bus.win_valid}, 0);
    start_frame(s0, base);
    wait_idle(30, "post_rst_idle");
    check_frame(base, s0, "post_rst");

    // random backpressure against the frame model
    for (int f = 0; f < 6; f++) begin
      repeat ($urandom_range(0, 3)) tick();
      start_frame(s0, base);
      for (int n = 0; n < 200; n++) begin
        tick();
        bus.win_ready = (f % 2 == 1) ? ($urandom_range(0, 1) == 1)
                                     : ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (!bus.busy) break;
      end
      bus.win_ready = 1'b1;
      check("rand_idle", bus.busy, 0);
      check_frame(base, s0, $sformatf("rand%0d", f));
    end
`endif

    tick();
    check("stall_stable", stall_bad, 0);
    check("done_rule", done_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
